branch_table_clear_ctrl: RTL and testbench

//  Owns the write ports of the branch predictor tag/target RAMs (one pair per way).

---
 rtl/cva5_types.sv | 13 +
 rtl/branch_table_clear_ctrl.sv | 99 +++++++++
 tb/tb_branch_table_clear_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cva5_types.sv
// Shared types for the branch predictor: invalidation sweep state encoding and
// the tag entry pattern used while clearing the tables.
package cva5_types;

   typedef enum logic {
      BP_CLR_IDLE,
      BP_CLR_SWEEP
   } bp_clear_state_t;

   // All-zero tag entry: valid bit clear, so a sweep write makes the entry miss.
   localparam logic BP_CLEAR_ENTRY = '0;

endpackage

// File: rtl/branch_table_clear_ctrl.sv
// Owns the per-way tag/target RAM write ports of the branch predictor and arbitrates
// execution-stage updates against a sequential invalidation sweep (reset, fence.i, satp).
//
// state        | meaning
// BP_CLR_IDLE  | updates pass straight through to the RAM write ports
// BP_CLR_SWEEP | one entry per cycle is invalidated in every way; updates are dropped
module branch_table_clear_ctrl
   import cva5_types::*;
#(
   parameter int WAYS          = 2,
   parameter int ENTRIES       = 512,
   parameter int INIT_ON_RESET = 1,
   localparam int ADDR_W       = $clog2(ENTRIES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_req,
   input  logic                     upd_valid,
   input  logic [WAYS*ADDR_W-1:0]   upd_addr,
   input  logic [WAYS-1:0]          upd_tag_way,
   input  logic [WAYS-1:0]          upd_target_way,
   output logic [WAYS-1:0]          tag_wr_en,
   output logic [WAYS-1:0]          target_wr_en,
   output logic [WAYS*ADDR_W-1:0]   wr_addr,
   output logic                     wr_invalidate,
   output logic                     predict_inhibit,
   output logic                     busy,
   output logic                     upd_dropped
);

   localparam bp_clear_state_t RESET_STATE = (INIT_ON_RESET != 0) ? BP_CLR_SWEEP : BP_CLR_IDLE;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ENTRIES - 1);
   localparam logic              RESET_BUSY = (INIT_ON_RESET != 0);

   bp_clear_state_t state, state_next;
   logic [ADDR_W-1:0] idx, idx_next;
   logic              busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RESET_STATE;
         idx    <= '0;
         busy_d <= RESET_BUSY;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         busy_d <= busy;
      end
   end

   always_comb begin
      state_next    = state;
      idx_next      = idx;
      tag_wr_en     = '0;
      target_wr_en  = '0;
      wr_addr       = upd_addr;
      wr_invalidate = 1'b0;
      upd_dropped   = 1'b0;
      busy          = 1'b0;

      case (state)
         BP_CLR_IDLE: begin
            idx_next = '0;
            if (upd_valid) begin
               tag_wr_en    = upd_tag_way;
               target_wr_en = upd_tag_way & upd_target_way;
            end
            if (flush_req)
               state_next = BP_CLR_SWEEP;
         end
         BP_CLR_SWEEP: begin
            busy          = 1'b1;
            wr_invalidate = 1'b1;
            tag_wr_en     = '1;
            upd_dropped   = upd_valid;
            for (int w = 0; w < WAYS; w++)
               wr_addr[w*ADDR_W +: ADDR_W] = idx;
            // A flush during a sweep restarts it rather than queueing another one.
            if (flush_req) begin
               idx_next = '0;
            end else begin
               idx_next = idx + 1'b1;
               if (idx == LAST_IDX)
                  state_next = BP_CLR_IDLE;
            end
         end
      endcase

      if (rst) begin
         tag_wr_en    = '0;
         target_wr_en = '0;
         upd_dropped  = 1'b0;
      end
   end

   // RAM reads have one cycle of latency, so inhibit outlives the last clear write by a cycle.
   assign predict_inhibit = busy | busy_d;

endmodule

// File: tb/tb_branch_table_clear_ctrl.sv
// Directed bench for branch_table_clear_ctrl with ENTRIES=8, WAYS=2; one instance
// starts a sweep out of reset, the other comes up idle.
module tb_branch_table_clear_ctrl;
   import cva5_types::*;

   localparam int WAYS    = 2;
   localparam int ENTRIES = 8;
   localparam int ADDR_W  = 3;

   logic clk = 1'b0;
   logic rst1, rst0;
   logic flush_req, upd_valid;
   logic [WAYS*ADDR_W-1:0] upd_addr;
   logic [WAYS-1:0] upd_tag_way, upd_target_way;

   logic [WAYS-1:0] tag_wr_en1, target_wr_en1, tag_wr_en0, target_wr_en0;
   logic [WAYS*ADDR_W-1:0] wr_addr1, wr_addr0;
   logic inv1, inh1, busy1, drop1, inv0, inh0, busy0, drop0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_table_clear_ctrl #(.WAYS(WAYS), .ENTRIES(ENTRIES), .INIT_ON_RESET(1)) dut (
      .clk(clk), .rst(rst1), .flush_req(flush_req), .upd_valid(upd_valid),
      .upd_addr(upd_addr), .upd_tag_way(upd_tag_way), .upd_target_way(upd_target_way),
      .tag_wr_en(tag_wr_en1), .target_wr_en(target_wr_en1), .wr_addr(wr_addr1),
      .wr_invalidate(inv1), .predict_inhibit(inh1), .busy(busy1), .upd_dropped(drop1));

   branch_table_clear_ctrl #(.WAYS(WAYS), .ENTRIES(ENTRIES), .INIT_ON_RESET(0)) dut0 (
      .clk(clk), .rst(rst0), .flush_req(flush_req), .upd_valid(upd_valid),
      .upd_addr(upd_addr), .upd_tag_way(upd_tag_way), .upd_target_way(upd_target_way),
      .tag_wr_en(tag_wr_en0), .target_wr_en(target_wr_en0), .wr_addr(wr_addr0),
      .wr_invalidate(inv0), .predict_inhibit(inh0), .busy(busy0), .upd_dropped(drop0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic no_upd();
      upd_valid      = 1'b0;
      upd_addr       = '0;
      upd_tag_way    = '0;
      upd_target_way = '0;
   endtask

   function automatic logic [5:0] both(input logic [2:0] a);
      return {a, a};
   endfunction

   initial begin
      rst1 = 1'b1;
      rst0 = 1'b1;
      flush_req = 1'b0;
      no_upd();

      // reset state
      smp();
      chk("rst_tag_en1", 32'(tag_wr_en1), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd1);
      chk("rst_inh1", 32'(inh1), 32'd1);
      chk("rst_inv1", 32'(inv1), 32'd1);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_inh0", 32'(inh0), 32'd0);
      tick();
      tick();
      rst1 = 1'b0;
      rst0 = 1'b0;

      // 1: initial sweep after reset release
      for (int i = 0; i < ENTRIES; i++) begin
         smp();
         chk($sformatf("init_tag_en_%0d", i), 32'(tag_wr_en1), 32'd3);
         chk($sformatf("init_addr_%0d", i), 32'(wr_addr1), 32'(both(3'(i))));
         chk($sformatf("init_tgt_en_%0d", i), 32'(target_wr_en1), 32'd0);
         chk($sformatf("init_busy_%0d", i), 32'(busy1), 32'd1);
         tick();
      end
      smp();
      chk("init_busy_fall", 32'(busy1), 32'd0);
      chk("init_inh_hold", 32'(inh1), 32'd1);
      chk("init_tag_en_done", 32'(tag_wr_en1), 32'd0);
      tick();
      smp();
      chk("init_inh_fall", 32'(inh1), 32'd0);

      // 2: idle pass-through, then target bits outside the tag way are masked
      upd_valid = 1'b1; upd_tag_way = 2'b10; upd_target_way = 2'b10; upd_addr = 6'b011_101;
      smp();
      chk("pass_tag_en", 32'(tag_wr_en1), 32'b10);
      chk("pass_tgt_en", 32'(target_wr_en1), 32'b10);
      chk("pass_addr", 32'(wr_addr1), 32'b011_101);
      chk("pass_inv", 32'(inv1), 32'd0);
      chk("pass_drop", 32'(drop1), 32'd0);
      tick();
      upd_tag_way = 2'b01; upd_target_way = 2'b11; upd_addr = 6'b110_010;
      smp();
      chk("mask_tag_en", 32'(tag_wr_en1), 32'b01);
      chk("mask_tgt_en", 32'(target_wr_en1), 32'b01);
      chk("mask_addr", 32'(wr_addr1), 32'b110_010);
      tick();
      no_upd();

      // 3+4: restart mid-sweep, update dropped while clearing
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smp();
         chk($sformatf("pre_addr_%0d", i), 32'(wr_addr1), 32'(both(3'(i))));
         tick();
      end
      flush_req = 1'b1;
      smp();
      chk("restart_at5", 32'(wr_addr1), 32'(both(3'd5)));
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (i == 2) begin
            upd_valid = 1'b1; upd_tag_way = 2'b01; upd_target_way = 2'b01; upd_addr = 6'b111_111;
         end
         smp();
         chk($sformatf("rs_addr_%0d", i), 32'(wr_addr1), 32'(both(3'(i))));
         chk($sformatf("rs_busy_%0d", i), 32'(busy1), 32'd1);
         chk($sformatf("rs_drop_%0d", i), 32'(drop1), (i == 2) ? 32'd1 : 32'd0);
         if (i == 2) begin
            chk("drop_tgt_en", 32'(target_wr_en1), 32'd0);
            chk("drop_tag_en", 32'(tag_wr_en1), 32'd3);
            chk("drop_inv", 32'(inv1), 32'd1);
         end
         tick();
         no_upd();
      end
      smp();
      chk("rs_busy_fall", 32'(busy1), 32'd0);
      chk("rs_inh_hold", 32'(inh1), 32'd1);
      tick();

      // 5: reset the idle-default instance at idx 3
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick(); tick(); tick();
      smp();
      chk("pre_rst_addr0", 32'(wr_addr0), 32'(both(3'd3)));
      chk("pre_rst_busy0", 32'(busy0), 32'd1);
      rst0 = 1'b1;
      #1;
      chk("rst_mid_tag_en0", 32'(tag_wr_en0), 32'd0);
      chk("rst_mid_busy0", 32'(busy0), 32'd0);
      tick();
      rst0 = 1'b0;
      upd_valid = 1'b1; upd_tag_way = 2'b01; upd_target_way = 2'b00; upd_addr = 6'b010_110;
      smp();
      chk("post_rst_busy0", 32'(busy0), 32'd0);
      chk("post_rst_inh0", 32'(inh0), 32'd0);
      chk("post_rst_tag_en0", 32'(tag_wr_en0), 32'b01);
      chk("post_rst_tgt_en0", 32'(target_wr_en0), 32'b00);
      chk("post_rst_addr0", 32'(wr_addr0), 32'b010_110);
      tick();
      no_upd();
      begin
         int budget = 20;
         while (inh1 && budget > 0) begin
            tick();
            budget--;
         end
         chk("drain_timeout", 32'(inh1), 32'd0);
      end

      // 6: flush and update together in idle
      flush_req = 1'b1;
      upd_valid = 1'b1; upd_tag_way = 2'b10; upd_target_way = 2'b10; upd_addr = 6'b001_100;
      smp();
      chk("fu_tag_en", 32'(tag_wr_en1), 32'b10);
      chk("fu_tgt_en", 32'(target_wr_en1), 32'b10);
      chk("fu_addr", 32'(wr_addr1), 32'b001_100);
      chk("fu_inv", 32'(inv1), 32'd0);
      tick();
      flush_req = 1'b0;
      no_upd();
      smp();
      chk("fu_sweep_tag_en", 32'(tag_wr_en1), 32'd3);
      chk("fu_sweep_addr", 32'(wr_addr1), 32'd0);
      chk("fu_sweep_inv", 32'(inv1), 32'd1);
      chk("fu_sweep_busy", 32'(busy1), 32'd1);
      for (int i = 0; i < ENTRIES; i++) tick();
      smp();
      chk("fu_busy_fall", 32'(busy1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
